// File: rtl/seg_pkg.sv
// Shared constants and types for the 7-segment display path.
package seg_pkg;

    localparam int unsigned SEG_DIGIT_W         = 4;
    localparam int unsigned SEG_SCAN_DIV_DEF    = 1000;
    localparam int unsigned SEG_DEAD_CYCLES_DEF = 1;
    localparam int unsigned SEG_MAX_DIGITS      = 32;

    // No digit blanked; sliced down to the display width where used
    localparam logic [SEG_MAX_DIGITS-1:0] DIGIT_BLANK_NONE = '0;

    typedef enum logic {
        ST_IDLE,
        ST_SCAN
    } scan_st_e;

endpackage

// File: rtl/seg_scan_prescaler.sv
// Slot prescaler: counts 0..DIV-1 while enabled and flags the wrap cycle.
module seg_scan_prescaler
    import seg_pkg::*;
#(
    parameter  int unsigned DIV = SEG_SCAN_DIV_DEF,
    localparam int unsigned CW  = $clog2(DIV)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic [CW-1:0] cnt_nxt_c,
    output logic          wrap_c
);

    logic [CW-1:0] cnt;

    assign wrap_c = en && (cnt == CW'(DIV - 1));

    always_comb begin
        cnt_nxt_c = cnt;
        if (wrap_c) begin
            cnt_nxt_c = '0;
        end else if (en) begin
            cnt_nxt_c = cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt_c;
        end
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed digit scanner feeding seven_seg_mux; frame-snapshotted digits.
// Optional leading-zero blanking under `SEG_LEADING_ZERO_BLANK_EN.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS  = 6,
    parameter int unsigned SCAN_DIV    = SEG_SCAN_DIV_DEF,
    parameter int unsigned DEAD_CYCLES = SEG_DEAD_CYCLES_DEF
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              en,
    input  logic [SEG_DIGIT_W*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]             dp_mask,
    output logic [SEG_DIGIT_W-1:0]            val,
    output logic                              dp,
    output logic [NUM_DIGITS-1:0]             dig_sel_n,
    output logic                              frame_start
);

    localparam int unsigned CW = $clog2(SCAN_DIV);
    localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    scan_st_e st, st_nxt;
    logic [IW-1:0] idx, idx_nxt;
    logic [NUM_DIGITS-1:0][SEG_DIGIT_W-1:0] dig_buf, dig_buf_nxt;
    logic [NUM_DIGITS-1:0] dp_buf, dp_buf_nxt;
    logic [NUM_DIGITS-1:0] blank_nxt;
    logic load;

    logic [CW-1:0] cnt_nxt;
    logic          wrap;
    logic          pre_en;

    logic [SEG_DIGIT_W-1:0] val_nxt;
    logic                   dp_nxt;
    logic [NUM_DIGITS-1:0]  sel_nxt;
    logic                   fs_nxt;

    // Prescaler only runs once the first enabled edge has opened slot 0
    assign pre_en = en && (st == ST_SCAN);

    seg_scan_prescaler #(
        .DIV (SCAN_DIV)
    ) u_pre (
        .clk       (clk),
        .rst       (rstn),
        .en        (pre_en),
        .cnt_nxt_c (cnt_nxt),
        .wrap_c    (wrap)
    );

    // Next digit index and frame snapshot
    always_comb begin
        st_nxt      = st;
        idx_nxt     = idx;
        dig_buf_nxt = dig_buf;
        dp_buf_nxt  = dp_buf;
        load        = 1'b0;
        if (en) begin
            if (st == ST_IDLE) begin
                st_nxt  = ST_SCAN;
                idx_nxt = '0;
                load    = 1'b1;
            end else if (wrap) begin
                if (idx == IW'(NUM_DIGITS - 1)) begin
                    idx_nxt = '0;
                    load    = 1'b1;
                end else begin
                    idx_nxt = idx + IW'(1);
                end
            end
        end
        if (load) begin
            dig_buf_nxt = digits_in;
            dp_buf_nxt  = dp_mask;
        end
    end

`ifdef SEG_LEADING_ZERO_BLANK_EN
    logic hi_zero;

    // A digit is blanked while it and every digit above it are zero
    always_comb begin
        blank_nxt = NUM_DIGITS'(DIGIT_BLANK_NONE);
        hi_zero   = 1'b1;
        for (int k = int'(NUM_DIGITS) - 1; k >= 1; k--) begin
            hi_zero      = hi_zero & (dig_buf_nxt[k] == '0);
            blank_nxt[k] = hi_zero;
        end
    end
`else
    assign blank_nxt = NUM_DIGITS'(DIGIT_BLANK_NONE);
`endif

    // Output values for the slot being entered on this edge
    always_comb begin
        val_nxt = val;
        dp_nxt  = dp;
        sel_nxt = '1;
        fs_nxt  = 1'b0;
        if (en) begin
            val_nxt = dig_buf_nxt[idx_nxt];
            dp_nxt  = dp_buf_nxt[idx_nxt];
            if ((cnt_nxt >= CW'(DEAD_CYCLES)) && !blank_nxt[idx_nxt]) begin
                sel_nxt[idx_nxt] = 1'b0;
            end
            fs_nxt = (idx_nxt == '0) && (cnt_nxt == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            st          <= ST_IDLE;
            idx         <= '0;
            dig_buf     <= '0;
            dp_buf      <= '0;
            val         <= '0;
            dp          <= 1'b0;
            dig_sel_n   <= '1;
            frame_start <= 1'b0;
        end else begin
            st          <= st_nxt;
            idx         <= idx_nxt;
            dig_buf     <= dig_buf_nxt;
            dp_buf      <= dp_buf_nxt;
            val         <= val_nxt;
            dp          <= dp_nxt;
            dig_sel_n   <= sel_nxt;
            frame_start <= fs_nxt;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Randomized bench for seg_scan_driver against a frame-position reference model.
module tb_seg_scan_driver;

    localparam int ND = 4;
    localparam int SD = 4;
    localparam int DC = 1;
    localparam int FL = ND * SD;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        en = 1'b0;
    logic [15:0] digits_in = '0;
    logic [3:0]  dp_mask = '0;
    logic [3:0]  val;
    logic        dp;
    logic [3:0]  dig_sel_n;
    logic        frame_start;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference: position within the frame plus the captured snapshot
    bit          m_run = 1'b0;
    int          m_pos = 0;
    logic [15:0] m_snap = '0;
    logic [3:0]  m_dps = '0;
    logic [3:0]  e_val = '0;
    logic        e_dp = 1'b0;
    logic [3:0]  e_sel = 4'hF;
    logic        e_fs = 1'b0;

    seg_scan_driver #(
        .NUM_DIGITS  (ND),
        .SCAN_DIV    (SD),
        .DEAD_CYCLES (DC)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .en          (en),
        .digits_in   (digits_in),
        .dp_mask     (dp_mask),
        .val         (val),
        .dp          (dp),
        .dig_sel_n   (dig_sel_n),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    function automatic bit m_blank(input int d);
`ifdef SEG_LEADING_ZERO_BLANK_EN
        return (d >= 1) && ((m_snap >> (4 * d)) == 16'h0);
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_step();
        int d;
        int c;
        if (rstn) begin
            m_run  = 1'b0;
            m_pos  = 0;
            m_snap = '0;
            m_dps  = '0;
            e_val  = '0;
            e_dp   = 1'b0;
            e_sel  = 4'hF;
            e_fs   = 1'b0;
        end else if (en) begin
            if (!m_run) begin
                m_run = 1'b1;
                m_pos = 0;
                m_snap = digits_in;
                m_dps  = dp_mask;
            end else begin
                m_pos = (m_pos + 1) % FL;
                if (m_pos == 0) begin
                    m_snap = digits_in;
                    m_dps  = dp_mask;
                end
            end
            d = m_pos / SD;
            c = m_pos % SD;
            e_val = 4'((m_snap >> (4 * d)) & 16'hF);
            e_dp  = m_dps[d];
            e_sel = 4'hF;
            if (c >= DC && !m_blank(d)) e_sel[d] = 1'b0;
            e_fs  = (m_pos == 0);
        end else begin
            e_sel = 4'hF;
            e_fs  = 1'b0;
        end
    endtask

    task automatic run(input logic r, input logic e, input logic [15:0] d,
                       input logic [3:0] m, input int n);
        repeat (n) begin
            @(negedge clk);
            rstn      = r;
            en        = e;
            digits_in = d;
            dp_mask   = m;
            @(posedge clk);
            #1;
            model_step();
            chk("val", 32'(val), 32'(e_val));
            chk("dp", 32'(dp), 32'(e_dp));
            chk("dig_sel_n", 32'(dig_sel_n), 32'(e_sel));
            chk("frame_start", 32'(frame_start), 32'(e_fs));
        end
    endtask

    function automatic logic [15:0] rand_digits();
        logic [15:0] r;
        r = '0;
        for (int k = 0; k < ND; k++) begin
            if ($urandom_range(0, 2) != 0) r[4*k +: 4] = 4'($urandom_range(0, 15));
        end
        return r;
    endfunction

    initial begin
        logic [15:0] rd;
        logic [3:0]  rm;

        run(1'b1, 1'b1, 16'h4321, 4'b0100, 3);
        run(1'b0, 1'b1, 16'h4321, 4'b0100, 40);
        run(1'b0, 1'b1, 16'h8765, 4'b0100, 12);
        run(1'b0, 1'b0, 16'h8765, 4'b0100, 5);
        run(1'b0, 1'b1, 16'h8765, 4'b0001, 20);
        run(1'b1, 1'b1, 16'h8765, 4'b0001, 2);
        run(1'b0, 1'b1, 16'h0050, 4'b0000, 36);
        run(1'b0, 1'b1, 16'h0000, 4'b1000, 36);
        run(1'b0, 1'b1, 16'h0A0F, 4'b0010, 36);

        rd = rand_digits();
        rm = 4'($urandom_range(0, 15));
        for (int i = 0; i < 1200; i++) begin
            if ($urandom_range(0, 15) == 0) rd = rand_digits();
            if ($urandom_range(0, 15) == 0) rm = 4'($urandom_range(0, 15));
            run(($urandom_range(0, 149) == 0), ($urandom_range(0, 7) != 0), rd, rm, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Time-multiplexed digit scanner for the 7-segment clock display.
- Sits directly upstream of seven_seg_mux. Takes a packed word of BCD/hex digits from the timekeeping logic and presents one digit at a time on val[3:0], which feeds seven_seg_mux.
- Drives the matching digit-select (anode) lines and decimal point.
- Snapshots the digit word once per frame so the display never tears mid-scan.

Parameters:
- NUM_DIGITS, 6: number of display digits; digit 0 is the rightmost (least significant).
- SCAN_DIV, 1000: clk cycles each digit stays selected; legal range >= 2.
- DEAD_CYCLES, 1: cycles at the start of each digit slot with all anodes off (anti-ghosting); legal range 0 .. SCAN_DIV-1.

Ports:
- clk  input  1  system clock
- rstn  input  1  synchronous reset, active-high (1 = reset)
- en  input  1  scan enable; 0 freezes the scan and blanks the display
- digits_in  input  4*NUM_DIGITS  packed digits; digit k occupies bits [4k+3:4k]
- dp_mask  input  NUM_DIGITS  decimal point request per digit, sampled with the snapshot
- val  output  4  current digit value, to seven_seg_mux.val
- dp  output  1  decimal point for the current digit
- dig_sel_n  output  NUM_DIGITS  active-low digit select, one-hot-low when driven
- frame_start  output  1  one-cycle pulse when digit 0's slot begins

Behaviour:
- Reset (rstn=1 at a clk edge):
  - pre_cnt=0, idx=0
  - frame buffer and dp buffer = 0
  - val=0, dp=0, dig_sel_n=all 1s, frame_start=0
  - Reset overrides en and all other activity, including mid-frame.
- First cycle after reset release (rstn=0, en=1):
  - Loads the snapshot from digits_in/dp_mask.
  - Starts digit 0's slot with pre_cnt=0.
- Prescaler:
  - pre_cnt counts 0..SCAN_DIV-1 while en=1.
  - At SCAN_DIV-1, pre_cnt wraps to 0 and idx advances; idx wraps from NUM_DIGITS-1 to 0.
- Snapshot:
  - On the edge where idx becomes 0, and on the first enabled edge after reset, buffers load from digits_in/dp_mask.
  - Changes to the inputs within a frame are not visible until the next frame.
- Outputs are registers updated on the same edge as idx/pre_cnt, so they are aligned with the slot:
  - val = buf digit[idx]. Values 0xA-0xF pass through unchanged; seven_seg_mux decodes them.
  - dp = dp_buf[idx].
  - dig_sel_n: bit idx = 0 only when pre_cnt >= DEAD_CYCLES and the digit is not blanked; otherwise all 1s.
  - frame_start = 1 for exactly the first cycle of idx=0's slot.
- en=0:
  - pre_cnt and idx hold.
  - dig_sel_n = all 1s and frame_start = 0 on the next edge.
  - val and dp hold.
  - On en returning to 1, counting resumes from the held pre_cnt; the slot is not restarted.
- Simultaneous events: reset beats en; snapshot load and idx wrap occur on the same edge.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro: SEG_LEADING_ZERO_BLANK_EN
- Defined:
  - Digit k (k >= 1) is blanked when buf digit k and all higher digits are 0.
  - Blanked digits keep dig_sel_n all 1s for the whole slot; val still shows 0.
  - Digit 0 is never blanked.
  - Blanking is evaluated on the snapshot, not live inputs.
- Undefined: every digit is displayed; no blank logic is synthesised.

Decomposition:
- Shared package seg_pkg holds:
  - the BCD digit width constant (4)
  - a DIGIT_BLANK_NONE mask constant
  - the default SCAN_DIV/DEAD_CYCLES values used across the display path.
- One sub-module is natural: seg_scan_prescaler (pre_cnt plus slot-wrap strobe with enable), reusable by the colon-blink logic.
- Digit select and snapshot stay in the top module.

Test Plan (NUM_DIGITS=4, SCAN_DIV=4, DEAD_CYCLES=1 unless noted):
- Reset: hold rstn=1 for 2 edges mid-scan -> val=0, dp=0, dig_sel_n=4'b1111, frame_start=0. After release, slot 0 starts.
- Scan order: digits_in=16'h4321, en=1 -> val runs 1,2,3,4 for 4 cycles each, then repeats.
  - Within each slot, dig_sel_n is 1111 for cycle 1, then 1110/1101/1011/0111.
  - frame_start pulses every 16 cycles.
- Snapshot: change digits_in to 16'h8765 during idx=2 -> remaining slots show 3,4; the next frame shows 5,6,7,8.
- Enable: drop en for 5 cycles at pre_cnt=2 of idx=1 -> dig_sel_n=1111 and val holds 2. After re-enable, idx=1 runs its remaining 2 cycles, then idx=2.
- Decimal point: dp_mask=4'b0100 -> dp=1 only during the idx=2 slot.
- SEG_LEADING_ZERO_BLANK_EN: digits_in=16'h0050.
  - With macro: digits 3 and 2 stay 1111 for their whole slot; digits 1 and 0 are driven.
  - Without macro: all four anodes are driven.
  - With digits_in=16'h0000: only digit 0 is driven.
